// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter driving a shared enabled register's D/E inputs.
// Optional burst lock feature enabled by defining SHARED_REG_LOCK_EN.
module shared_reg_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [NUM_REQ-1:0]         lock,
`endif
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           reg_d,
    output logic                       reg_e,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   grant_id_q, grant_id_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;

    logic [WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [IdW-1:0]   winner;
    logic [IdW-1:0]   cand;
    logic             found;
    logic [IdW-1:0]   next_ptr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_ptr = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + IdW'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        reg_d_d    = reg_d_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StWrite;
                    grant_id_d = winner;
                    reg_d_d    = wdata_arr[winner];
                end
            end
            StWrite: begin
                state_d = StAck;
            end
            StAck: begin
`ifdef SHARED_REG_LOCK_EN
                if (lock[grant_id_q] && req[grant_id_q]) begin
                    state_d = StWrite;
                    reg_d_d = wdata_arr[grant_id_q];
                end else begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end
`else
                state_d  = StIdle;
                rr_ptr_d = next_ptr;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            reg_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            reg_d_q    <= reg_d_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == StAck) begin
            ack[grant_id_q] = 1'b1;
        end
    end

    assign reg_e    = (state_q == StWrite);
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_id_q;
    assign reg_d    = reg_d_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=4).
// Lock burst scenario runs only when SHARED_REG_LOCK_EN is defined.
module tb_shared_reg_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   lock;
    logic [N-1:0]   ack;
    logic [W-1:0]   reg_d;
    logic           reg_e;
    logic [1:0]     grant_id;
    logic           busy;
    logic [W-1:0]   reg_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock     (lock),
`endif
        .ack      (ack),
        .reg_d    (reg_d),
        .reg_e    (reg_e),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // Model of the downstream D/E register.
    always_ff @(posedge clk) begin
        if (reg_e) reg_q <= reg_d;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    // Checks the WRITE cycle of a grant: E high, winner id and latched data.
    task automatic check_write(input string tag, input logic [1:0] id, input logic [W-1:0] d);
        check_eq({tag, "_reg_e"}, 32'(reg_e), 32'd1);
        check_eq({tag, "_grant_id"}, 32'(grant_id), 32'(id));
        check_eq({tag, "_reg_d"}, 32'(reg_d), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        lock  = '0;
        reg_q = '0;

        // 1. Reset state held with no requests.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            check_eq("idle_outputs", {reg_e, ack, busy, grant_id, reg_d}, 32'd0);
            step();
        end

        // 2. Single request from requester 2.
        set_wd(2, 4'h1);
        req = 4'b0100;
        step();
        check_write("single", 2'd2, 4'h1);
        check_eq("single_busy", 32'(busy), 32'd1);
        set_wd(2, 4'h6);                       // late data change must be ignored
        check_eq("single_ack_early", 32'(ack), 32'd0);
        step();
        check_eq("single_ack", 32'(ack), 32'b0100);
        check_eq("single_reg_e_off", 32'(reg_e), 32'd0);
        check_eq("single_reg_q", 32'(reg_q), 32'h1);
        req = 4'b0000;
        step();
        check_eq("single_idle_busy", 32'(busy), 32'd0);
        check_eq("single_idle_ack", 32'(ack), 32'd0);
        step();
        check_eq("single_no_reg_e", 32'(reg_e), 32'd0);

        // 3. All requesting: strict rotation 0,1,2,3,0 every 3 cycles.
        do_reset();
        set_wd(0, 4'hA);
        set_wd(1, 4'hB);
        set_wd(2, 4'hC);
        set_wd(3, 4'hD);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            check_write("rr", 2'(g % 4), 4'hA + 4'(g % 4));
            step();
            check_eq("rr_ack", 32'(ack), 32'(1 << (g % 4)));
            check_eq("rr_reg_q", 32'(reg_q), 32'(4'hA + 4'(g % 4)));
            step();
            check_eq("rr_gap_busy", 32'(busy), 32'd0);
        end
        req = 4'b0000;
        step();

        // 4. Pointer wrap after a grant to 3.
        do_reset();
        req = 4'b1000;
        step();
        check_write("wrap_first", 2'd3, 4'hD);
        req = 4'b1001;
        step();
        step();
        step();
        check_write("wrap_second", 2'd0, 4'hA);
        step();
        step();
        step();
        check_write("wrap_third", 2'd3, 4'hD);
        req = 4'b0000;
        step();
        step();

        // 5a. Request dropped during WRITE still completes.
        do_reset();
        req = 4'b0010;
        step();
        check_write("drop", 2'd1, 4'hB);
        req = 4'b0000;
        step();
        check_eq("drop_ack", 32'(ack), 32'b0010);
        step();
        check_eq("drop_idle", 32'(busy), 32'd0);

        // 5b. Reset during WRITE: no ack, E drops.
        req = 4'b0001;
        step();
        check_write("rst_wr", 2'd0, 4'hA);
        reset = 1'b1;
        req   = 4'b0000;
        step();
        check_eq("rst_wr_outputs", {reg_e, ack, busy}, 32'd0);
        reset = 1'b0;
        step();
        check_eq("rst_wr_no_ack", 32'(ack), 32'd0);

        // 5c. Reset during ACK: ack truncated, pointer back to 0.
        req = 4'b0010;
        step();
        check_write("rst_ack", 2'd1, 4'hB);
        step();
        check_eq("rst_ack_pulse", 32'(ack), 32'b0010);
        reset = 1'b1;
        req   = 4'b0110;
        step();
        check_eq("rst_ack_trunc", {ack, busy}, 32'd0);
        reset = 1'b0;
        step();
        check_write("rst_ack_ptr", 2'd1, 4'hB);
        req = 4'b0000;
        step();
        step();

`ifdef SHARED_REG_LOCK_EN
        // 6. Locked burst from requester 0, then release to 1.
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        step();
        check_write("lock_w0", 2'd0, 4'hA);
        step();
        check_eq("lock_ack0", 32'(ack), 32'b0001);
        set_wd(0, 4'h5);
        step();
        check_write("lock_w1", 2'd0, 4'h5);
        step();
        check_eq("lock_ack1", 32'(ack), 32'b0001);
        set_wd(0, 4'h7);
        step();
        check_write("lock_w2", 2'd0, 4'h7);
        lock = 4'b0000;
        step();
        check_eq("lock_ack2", 32'(ack), 32'b0001);
        step();
        check_eq("lock_release_idle", 32'(busy), 32'd0);
        step();
        check_write("lock_next", 2'd1, 4'hB);
        req = 4'b0000;
        step();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
